// File: rtl/ppu_render_sequencer.sv
// Dot/scanline timing for the PPU video path: dot and line counters, per-dot strobe word,
// vblank flag, NMI request and odd-frame dot skip.
module ppu_render_sequencer #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VISIBLE_LINES   = 240,
    parameter int VBLANK_LINE     = 241,
    parameter int PRERENDER_LINE  = 261
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_clken,
    input  logic [7:0]  I_ppuctrl,
    input  logic [7:0]  I_ppumask,
    input  logic        I_status_rd,
    output logic [8:0]  O_dot,
    output logic [8:0]  O_line,
    output logic [15:0] O_control,
    output logic        O_vblank,
    output logic        O_nmi_n,
    output logic        O_frame_odd
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_SKIP  = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] LINE_VIS  = 9'(VISIBLE_LINES);
    localparam logic [8:0] LINE_VBL  = 9'(VBLANK_LINE);
    localparam logic [8:0] LINE_PRE  = 9'(PRERENDER_LINE);

    logic [8:0]  dot_q, dot_d, line_q, line_d;
    logic        odd_q, odd_d, vblank_q, vblank_d, nmi_n_q, nmi_n_d;
    logic        rendering, vbl_set, vbl_clr;
    logic        f_line, vis_line, fetch;
    logic [2:0]  ph;
    logic [15:0] ctl_raw, ctl_mask;
    logic        unused_bits;

    assign unused_bits = ^{I_ppuctrl[6:0], I_ppumask[7:5], I_ppumask[2:0]};
    assign rendering   = I_ppumask[3] | I_ppumask[4];
    assign vbl_set     = I_clken && (line_q == LINE_VBL) && (dot_q == 9'd1);
    assign vbl_clr     = I_clken && (line_q == LINE_PRE) && (dot_q == 9'd1);

    always_comb begin
        dot_d  = dot_q;
        line_d = line_q;
        odd_d  = odd_q;
        if (I_clken) begin
            // Odd frames with rendering on drop the last dot of the pre-render line.
            if ((line_q == LINE_PRE) && (dot_q == DOT_SKIP) && odd_q && rendering) begin
                dot_d  = 9'd0;
                line_d = 9'd0;
                odd_d  = ~odd_q;
            end else if (dot_q == DOT_LAST) begin
                dot_d = 9'd0;
                if (line_q == LINE_LAST) begin
                    line_d = 9'd0;
                    odd_d  = ~odd_q;
                end else begin
                    line_d = line_q + 9'd1;
                end
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end

        // A status read races the set and the clear; the read always wins.
        vblank_d = vblank_q;
        if (vbl_set && !I_status_rd) vblank_d = 1'b1;
        if (vbl_clr || I_status_rd)  vblank_d = 1'b0;

        nmi_n_d = ~(vblank_q & I_ppuctrl[7]);
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            dot_q    <= 9'd0;
            line_q   <= 9'd0;
            odd_q    <= 1'b0;
            vblank_q <= 1'b0;
            nmi_n_q  <= 1'b1;
        end else begin
            dot_q    <= dot_d;
            line_q   <= line_d;
            odd_q    <= odd_d;
            vblank_q <= vblank_d;
            nmi_n_q  <= nmi_n_d;
        end
    end

    assign f_line   = (line_q < LINE_VIS) || (line_q == LINE_PRE);
    assign vis_line = line_q < LINE_VIS;
    assign ph       = dot_q[2:0] - 3'd1;
    assign fetch    = f_line && (((dot_q >= 9'd1) && (dot_q <= 9'd256)) ||
                                 ((dot_q >= 9'd321) && (dot_q <= 9'd336)));

    always_comb begin
        ctl_raw     = 16'h0000;
        ctl_raw[0]  = fetch && (ph == 3'd0);
        ctl_raw[1]  = fetch && (ph == 3'd2);
        ctl_raw[2]  = fetch && (ph == 3'd4);
        ctl_raw[3]  = fetch && (ph == 3'd6);
        ctl_raw[4]  = f_line && (((dot_q >= 9'd9) && (dot_q <= 9'd257) && (ph == 3'd0)) ||
                                 (dot_q == 9'd329) || (dot_q == 9'd337));
        ctl_raw[5]  = f_line && (((dot_q >= 9'd2) && (dot_q <= 9'd257)) ||
                                 ((dot_q >= 9'd322) && (dot_q <= 9'd337)));
        ctl_raw[6]  = fetch && (ph == 3'd7);
        ctl_raw[7]  = f_line && (dot_q == 9'd256);
        ctl_raw[8]  = f_line && (dot_q == 9'd257);
        ctl_raw[9]  = (line_q == LINE_PRE) && (dot_q >= 9'd280) && (dot_q <= 9'd304);
        ctl_raw[10] = vis_line && (dot_q >= 9'd1) && (dot_q <= 9'd256);
        ctl_raw[11] = vis_line && (dot_q >= 9'd65) && (dot_q <= 9'd256);
        ctl_raw[12] = f_line && (dot_q >= 9'd257) && (dot_q <= 9'd320);
        ctl_raw[13] = line_q == LINE_PRE;
        ctl_raw[14] = (dot_q == 9'd0) || (dot_q > 9'd256);
    end

    // Pixel, pre-render and hblank strobes stay live with rendering off.
    assign ctl_mask  = rendering ? 16'h7FFF : 16'h6400;
    assign O_control = (I_clken && !I_reset) ? (ctl_raw & ctl_mask) : 16'h0000;

    assign O_dot       = dot_q;
    assign O_line      = line_q;
    assign O_vblank    = vblank_q;
    assign O_nmi_n     = nmi_n_q;
    assign O_frame_odd = odd_q;

endmodule

// File: tb/tb_ppu_render_sequencer.sv
// Scoreboard bench for ppu_render_sequencer on a shortened frame (8 lines) so whole
// frame pairs, vblank and the odd skip fit in a short run.
module tb_ppu_render_sequencer;

    localparam int DOTS  = 341;
    localparam int LINES = 8;
    localparam int VIS   = 4;
    localparam int VBL   = 5;
    localparam int PRE   = 7;
    localparam int FRAME = LINES * DOTS;

    logic        clk = 1'b0;
    logic        rst_i, en_i, rd_i;
    logic [7:0]  ctrl_i, mask_i;
    logic [8:0]  o_dot, o_line;
    logic [15:0] o_ctl;
    logic        o_vbl, o_nmi_n, o_odd;

    always #5 clk = ~clk;

    ppu_render_sequencer #(
        .DOTS_PER_LINE  (DOTS),
        .LINES_PER_FRAME(LINES),
        .VISIBLE_LINES  (VIS),
        .VBLANK_LINE    (VBL),
        .PRERENDER_LINE (PRE)
    ) dut (
        .I_clock    (clk),
        .I_reset    (rst_i),
        .I_clken    (en_i),
        .I_ppuctrl  (ctrl_i),
        .I_ppumask  (mask_i),
        .I_status_rd(rd_i),
        .O_dot      (o_dot),
        .O_line     (o_line),
        .O_control  (o_ctl),
        .O_vblank   (o_vbl),
        .O_nmi_n    (o_nmi_n),
        .O_frame_odd(o_odd)
    );

    typedef struct packed {
        logic [8:0]  dot;
        logic [8:0]  line;
        logic [15:0] ctl;
        logic        vbl;
        logic        nmi_n;
        logic        odd;
    } obs_t;

    obs_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: linear position within the frame plus flags.
    int m_pos;
    bit m_odd, m_vbl, m_nmi_n;

    function automatic logic [15:0] ref_control(int dot, int line, bit en, bit rs, bit rend);
        logic [15:0] c;
        bit fl, vis, fd;
        int ph;
        c   = '0;
        fl  = (line < VIS) || (line == PRE);
        vis = line < VIS;
        fd  = (dot >= 1 && dot <= 256) || (dot >= 321 && dot <= 336);
        ph  = (dot + 7) % 8;
        if (fl && fd && (ph % 2 == 0)) c[ph / 2] = 1'b1;
        if (fl && fd && ph == 7) c[6] = 1'b1;
        if (fl && ((dot >= 9 && dot <= 257 && ph == 0) || dot == 329 || dot == 337)) c[4] = 1'b1;
        c[5]  = fl && ((dot >= 2 && dot <= 257) || (dot >= 322 && dot <= 337));
        c[7]  = fl && dot == 256;
        c[8]  = fl && dot == 257;
        c[9]  = (line == PRE) && dot >= 280 && dot <= 304;
        c[10] = vis && dot >= 1 && dot <= 256;
        c[11] = vis && dot >= 65 && dot <= 256;
        c[12] = fl && dot >= 257 && dot <= 320;
        c[13] = line == PRE;
        c[14] = (dot == 0) || (dot > 256);
        if (!rend) c = c & 16'h6400;
        if (!en || rs) c = '0;
        return c;
    endfunction

    function automatic void model_update(bit r, bit e, logic [7:0] c, logic [7:0] m, bit rd);
        int dot, line;
        dot  = m_pos % DOTS;
        line = m_pos / DOTS;
        if (r) begin
            m_pos = 0; m_odd = 0; m_vbl = 0; m_nmi_n = 1;
            return;
        end
        m_nmi_n = !(m_vbl && c[7]);
        if (e && line == VBL && dot == 1 && !rd) m_vbl = 1;
        if ((e && line == PRE && dot == 1) || rd) m_vbl = 0;
        if (e) begin
            if (line == PRE && dot == DOTS - 2 && m_odd && (m[3] | m[4])) m_pos = FRAME;
            else m_pos = m_pos + 1;
            if (m_pos == FRAME) begin
                m_pos = 0;
                m_odd = !m_odd;
            end
        end
    endfunction

    task automatic step(input bit r, input bit e, input logic [7:0] c, input logic [7:0] m,
                        input bit rd);
        obs_t ex;
        rst_i = r; en_i = e; ctrl_i = c; mask_i = m; rd_i = rd;
        ex.dot   = 9'(m_pos % DOTS);
        ex.line  = 9'(m_pos / DOTS);
        ex.ctl   = ref_control(m_pos % DOTS, m_pos / DOTS, e, r, m[3] | m[4]);
        ex.vbl   = m_vbl;
        ex.nmi_n = m_nmi_n;
        ex.odd   = m_odd;
        sb_q.push_back(ex);
        @(posedge clk);
        model_update(r, e, c, m, rd);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic run_to(input int target, input bit want_even, input logic [7:0] c,
                          input logic [7:0] m);
        int n;
        n = 0;
        while (!(m_pos == target && (!want_even || !m_odd)) && n < 3 * FRAME) begin
            step(0, 1, c, m, 0);
            n++;
        end
        if (n >= 3 * FRAME) check("run_to_timeout", n, 0);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                obs_t ex, got;
                ex        = sb_q.pop_front();
                got.dot   = o_dot;
                got.line  = o_line;
                got.ctl   = o_ctl;
                got.vbl   = o_vbl;
                got.nmi_n = o_nmi_n;
                got.odd   = o_odd;
                checks++;
                if (got !== ex) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got dot=%0d line=%0d ctl=%h vbl=%b nmi_n=%b odd=%b exp dot=%0d line=%0d ctl=%h vbl=%b nmi_n=%b odd=%b",
                             $time, got.dot, got.line, got.ctl, got.vbl, got.nmi_n, got.odd,
                             ex.dot, ex.line, ex.ctl, ex.vbl, ex.nmi_n, ex.odd);
                end
            end
        end
    end

    initial begin
        int n, bad;
        bit done;
        logic [7:0] m;
        int t2_dot[8] = '{1, 3, 5, 7, 8, 9, 256, 257};
        int t2_bit[8] = '{0, 1, 2, 3, 6, 4, 7, 8};

        rst_i = 1; en_i = 1; ctrl_i = 8'h00; mask_i = 8'h18; rd_i = 0;
        @(posedge clk);
        #1;
        m_pos = 0; m_odd = 0; m_vbl = 0; m_nmi_n = 1;

        // Reset held with busy inputs: outputs at reset values, control word 0.
        for (int i = 0; i < 3; i++) step(1, 1, 8'hFF, 8'hFF, 1);

        // Line 0 strobes and dot wrap with background rendering only.
        for (int i = 1; i <= 345; i++) begin
            step(0, 1, 8'h00, 8'h08, 0);
            for (int k = 0; k < 8; k++)
                if (i == t2_dot[k]) check($sformatf("t2_bit%0d_dot%0d", t2_bit[k], i),
                                          int'(o_ctl[t2_bit[k]]), 1);
            if (i == 2) check("t2_bit0_dot2", int'(o_ctl[0]), 0);
            if (i == 340) check("t1_dot340", int'(o_dot), 340);
            if (i == 341) begin
                check("t1_wrap_dot", int'(o_dot), 0);
                check("t1_wrap_line", int'(o_line), 1);
            end
        end

        // Gated clock enable with random inputs, then a mid-frame reset.
        done = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i > 600 && !done && (m_pos / DOTS) == 3) begin
                step(1, $urandom_range(0, 1), 8'($urandom), 8'($urandom), 0);
                done = 1;
                check("t6_reset_dot", int'(o_dot), 0);
                check("t6_reset_line", int'(o_line), 0);
                check("t6_reset_odd", int'(o_odd), 0);
            end else begin
                step(0, $urandom_range(0, 1), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 31) == 0));
            end
        end
        check("t6_reset_taken", int'(done), 1);

        // Vblank set, NMI follow of ctrl bit7, status read clear.
        m = 8'($urandom) | 8'h08;
        run_to(VBL * DOTS + 1, 0, 8'h80, m);
        step(0, 1, 8'h80, m, 0);
        check("t3_vbl_set", int'(o_vbl), 1);
        check("t3_nmi_lag", int'(o_nmi_n), 1);
        step(0, 1, 8'h80, m, 0);
        check("t3_nmi_assert", int'(o_nmi_n), 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h80, m, 0);
        step(0, 1, 8'h00, m, 0);
        check("t3_nmi_ctrl_off", int'(o_nmi_n), 1);
        step(0, 1, 8'h80, m, 0);
        check("t3_nmi_ctrl_on", int'(o_nmi_n), 0);
        step(0, 1, 8'h80, m, 1);
        check("t3_rd_clears_vbl", int'(o_vbl), 0);
        step(0, 1, 8'h80, m, 0);
        check("t3_rd_clears_nmi", int'(o_nmi_n), 1);

        // Status read on the exact set cycle suppresses vblank and NMI for the frame.
        m = 8'($urandom);
        run_to(VBL * DOTS + 1, 0, 8'h80, m);
        step(0, 1, 8'h80, m, 1);
        bad = 0;
        n = 0;
        do begin
            if (o_vbl || !o_nmi_n) bad++;
            step(0, 1, 8'h80, m, 0);
            n++;
        end while (m_pos != PRE * DOTS + 5 && n < FRAME);
        check("t4_suppressed_cycles", bad, 0);

        // Frame pair length with and without the odd-frame skip.
        run_to(0, 1, 8'h00, 8'h18);
        n = 0;
        do begin
            step(0, 1, 8'h00, 8'h18, 0);
            n++;
        end while (!(o_odd == 0 && o_dot == 0 && o_line == 0) && n < 3 * FRAME);
        check("t5_pair_render_on", n, 2 * FRAME - 1);
        n = 0;
        do begin
            step(0, 1, 8'h00, 8'h00, 0);
            n++;
        end while (!(o_odd == 0 && o_dot == 0 && o_line == 0) && n < 3 * FRAME);
        check("t5_pair_render_off", n, 2 * FRAME);

        // Free-running random traffic.
        for (int i = 0; i < 6000; i++)
            step(0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 63) == 0));

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
